// File: rtl/mem_bus_responder_if.sv
// Request/response bus between a memory master and mem_bus_responder.
// Master drives requests and rsp_ready; the slave answers with req_ready and tagged responses.
interface mem_bus_responder_if #(
    parameter int DATA_SIZE   = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int TAG_WIDTH   = 8,
    parameter int FLAGS_WIDTH = 4
);
    logic                   req_valid;
    logic                   req_rw;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_SIZE*8-1:0] req_data;
    logic [DATA_SIZE-1:0]   req_byteen;
    logic [FLAGS_WIDTH-1:0] req_flags;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   req_ready;
    logic                   rsp_valid;
    logic [DATA_SIZE*8-1:0] rsp_data;
    logic [TAG_WIDTH-1:0]   rsp_tag;
    logic                   rsp_ready;

    modport master (
        output req_valid, req_rw, req_addr, req_data, req_byteen, req_flags, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data, req_byteen, req_flags, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-bus slave: DEPTH-word byte-writable memory, fixed-latency reads, credit-guarded response FIFO.
// Define MEM_BUS_WRITE_ACK_EN to make writes return an in-order response (data 0, echoed tag).
module mem_bus_responder #(
    parameter int DATA_SIZE   = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int TAG_WIDTH   = 8,
    parameter int FLAGS_WIDTH = 4,
    parameter int DEPTH       = 1024,
    parameter int LATENCY     = 2,
    parameter int RSP_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_responder_if.slave bus
);
    localparam int DW = DATA_SIZE * 8;
    localparam int IW = $clog2(DEPTH);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RSP_DEPTH);

    if (DEPTH > (1 << ADDR_WIDTH) || LATENCY < 1 || RSP_DEPTH < 2) begin : g_bad_params
        $error("mem_bus_responder: illegal parameter combination");
    end

    logic [DW-1:0]          mem [DEPTH];
    logic [IW-1:0]          w_idx;
    logic                   w_acc_rd;
    logic                   w_acc_wr;
    logic                   w_take;
    logic                   w_take_zero;
    logic                   w_push;
    logic [DW-1:0]          w_push_data;
    logic [TAG_WIDTH-1:0]   w_push_tag;
    logic                   w_pop;
    logic                   w_rsp_valid;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          r_qcnt;
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [DW-1:0]          r_q_data [RSP_DEPTH];
    logic [TAG_WIDTH-1:0]   r_q_tag  [RSP_DEPTH];
    logic [FLAGS_WIDTH-1:0] w_flags_unused;
    logic [ADDR_WIDTH-1:0]  w_addr_unused;

    assign w_flags_unused = bus.req_flags;
    assign w_addr_unused  = bus.req_addr;
    assign w_idx          = bus.req_addr[IW-1:0];

    // Credits cover pipeline plus queue, so a full count is the only reason to stall.
    assign bus.req_ready = !reset && (r_cnt < FULL);
    assign w_acc_rd      = bus.req_valid && bus.req_ready && !bus.req_rw;
    assign w_acc_wr      = bus.req_valid && bus.req_ready && bus.req_rw;
    assign w_take_zero   = w_acc_wr;
`ifdef MEM_BUS_WRITE_ACK_EN
    assign w_take = w_acc_rd || w_acc_wr;
`else
    assign w_take = w_acc_rd;
`endif

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_SIZE; b++) begin
            if (w_acc_wr && bus.req_byteen[b]) begin
                mem[w_idx][b*8 +: 8] <= bus.req_data[b*8 +: 8];
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign w_push      = w_take;
            assign w_push_data = w_take_zero ? '0 : mem[w_idx];
            assign w_push_tag  = bus.req_tag;
        end else begin : g_pipe
            localparam int NS = LATENCY - 1;
            logic [DW-1:0]        r_rd_data;
            logic [NS-1:0]        r_vld;
            logic [NS-1:0]        r_zero;
            logic [TAG_WIDTH-1:0] r_tag [NS];
            logic [DW-1:0]        w_dat [NS];

            // Registered read returns the pre-write word, matching "value at start of cycle".
            always_ff @(posedge clk) begin
                r_rd_data <= mem[w_idx];
                r_tag[0]  <= bus.req_tag;
                r_zero[0] <= w_take_zero;
                for (int k = 1; k < NS; k++) begin
                    r_tag[k]  <= r_tag[k-1];
                    r_zero[k] <= r_zero[k-1];
                end
                if (reset) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_take;
                    for (int k = 1; k < NS; k++) begin
                        r_vld[k] <= r_vld[k-1];
                    end
                end
            end

            assign w_dat[0] = r_rd_data;
            for (genvar gi = 1; gi < NS; gi++) begin : g_stage
                logic [DW-1:0] r_dat;
                always_ff @(posedge clk) r_dat <= w_dat[gi-1];
                assign w_dat[gi] = r_dat;
            end

            assign w_push      = r_vld[NS-1];
            assign w_push_tag  = r_tag[NS-1];
            assign w_push_data = r_zero[NS-1] ? '0 : w_dat[NS-1];
        end
    endgenerate

    assign w_rsp_valid = (r_qcnt != '0);
    assign w_pop       = w_rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wptr] <= w_push_data;
            r_q_tag[r_wptr]  <= w_push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_qcnt <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_qcnt <= r_qcnt + CW'(1);
                2'b01:   r_qcnt <= r_qcnt - CW'(1);
                default: r_qcnt <= r_qcnt;
            endcase
            case ({w_take, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = w_rsp_valid ? r_q_data[r_rptr] : '0;
    assign bus.rsp_tag   = w_rsp_valid ? r_q_tag[r_rptr]  : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(w_push && (r_qcnt == FULL)));
endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed scenarios plus random traffic against
// a transaction-level model (word array + queue of expected responses with due cycles).
module tb_mem_bus_responder;
    localparam int LAT   = 2;
    localparam int RSPD  = 4;
    localparam int DEPTH = 1024;
    localparam int IW    = 10;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  t;
        int          due;
    } rsp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_bus_responder_if bus ();
    mem_bus_responder dut (.clk(clk), .reset(reset), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] mem_m [DEPTH];
    rsp_t        exp_q [$];

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic [7:0] t);
        bus.req_valid  = v;
        bus.req_rw     = rw;
        bus.req_addr   = a;
        bus.req_data   = d;
        bus.req_byteen = be;
        bus.req_tag    = t;
        bus.req_flags  = 4'($urandom_range(0, 15));
    endtask

    // One clock cycle: compare DUT outputs with the model, apply the handshakes, advance.
    task automatic step(output bit acc);
        bit          exp_rdy;
        bit          exp_vld;
        bit          pop;
        logic [IW-1:0] idx;
        rsp_t        e;
        #2;
        exp_rdy = !reset && (exp_q.size() < RSPD);
        exp_vld = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        check_val("req_ready", bus.req_ready, exp_rdy);
        check_val("rsp_valid", bus.rsp_valid, exp_vld);
        if (exp_vld) begin
            check_val("rsp_data", bus.rsp_data, exp_q[0].d);
            check_val("rsp_tag", bus.rsp_tag, exp_q[0].t);
        end
        acc = bus.req_valid && bus.req_ready;
        pop = bus.rsp_valid && bus.rsp_ready;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (pop) begin
                $display("[TB] cyc %0d rsp tag=%0d data=0x%08h", cyc, bus.rsp_tag, bus.rsp_data);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (acc) begin
                idx = bus.req_addr[IW-1:0];
                $display("[TB] cyc %0d req %s addr=0x%04h tag=%0d", cyc, bus.req_rw ? "WR" : "RD",
                         bus.req_addr, bus.req_tag);
                if (!bus.req_rw) begin
                    e.d = mem_m[idx]; e.t = bus.req_tag; e.due = cyc + LAT;
                    exp_q.push_back(e);
                end else begin
`ifdef MEM_BUS_WRITE_ACK_EN
                    e.d = '0; e.t = bus.req_tag; e.due = cyc + LAT;
                    exp_q.push_back(e);
`endif
                    for (int b = 0; b < 4; b++)
                        if (bus.req_byteen[b]) mem_m[idx][b*8 +: 8] = bus.req_data[b*8 +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 8'h0);
        repeat (n) step(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n_acc;
        int tag;
        int guard;
        logic [15:0] a;
        foreach (mem_m[i]) mem_m[i] = '0;
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 8'h0);
        bus.rsp_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        repeat (3) step(acc);
        check_val("rst_rsp_data", bus.rsp_data, 32'h0);
        check_val("rst_rsp_tag", bus.rsp_tag, 8'h0);
        reset = 1'b0;

        // Full write, read-after-write, partial write, aliased read.
        drive(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 8'd1); step(acc);
        check_val("wr1_acc", acc, 1);
        drive(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 8'd7);        step(acc);
        check_val("rd1_acc", acc, 1);
        idle(4);
        drive(1'b1, 1'b1, 16'h0010, 32'h0000CAFE, 4'h3, 8'd2); step(acc);
        drive(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 8'd8);        step(acc);
        drive(1'b1, 1'b0, 16'h0410, 32'h0, 4'h0, 8'd9);        step(acc);
        idle(4);

        // Credit limit with the response side stalled.
        bus.rsp_ready = 1'b0;
        tag = 0; n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (tag < 6) drive(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 8'(tag));
            else         drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 8'h0);
            step(acc);
            if (acc) begin n_acc++; tag++; end
        end
        check_val("credit_accepts", n_acc, 4);
        check_val("credit_ready_low", bus.req_ready, 0);
        bus.rsp_ready = 1'b1;
        idle(8);

        // Streaming reads over freshly written words.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 16'(16'h0020 + i), $urandom, 4'hF, 8'(100 + i)); step(acc);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 16'(16'h0020 + (i % 8)), 32'h0, 4'h0, 8'(16 + i)); step(acc);
            check_val("stream_acc", acc, 1);
        end
        idle(5);

        // Reset with reads in flight: nothing stale may come out afterwards.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'(16'h0020 + i), 32'h0, 4'h0, 8'(40 + i)); step(acc);
        end
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 8'h0);
        reset = 1'b1;
        step(acc);
        check_val("rst_flight_valid", bus.rsp_valid, 0);
        check_val("rst_flight_ready", bus.req_ready, 0);
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        idle(4);
        drive(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 8'd50); step(acc);
        idle(4);

        // Random traffic with aliasing upper address bits and random backpressure.
        for (int i = 0; i < 600; i++) begin
            a = 16'($urandom_range(0, 65535)) & 16'hFC1F;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                  4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            step(acc);
        end

        bus.rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 8'h0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            step(acc);
            guard++;
        end
        check_val("drain_empty", exp_q.size(), 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
